// File: rtl/csr_seq_pkg.sv
// Shared types and constants for the CSR access sequencer.
package csr_seq_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned REG_IDX_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ1,
    ST_WAIT1,
    ST_REQ2,
    ST_WAIT2,
    ST_DONE,
    ST_EXCP,
    ST_DRAIN
  } state_e;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [1:0] TMU_OP_NONE  = 2'b00;
  localparam logic [1:0] TMU_OP_WRITE = 2'b01;

  localparam logic [3:0] CAUSE_ILLEGAL_INSN = 4'd2;

  // funct3 000 and 100 are not Zicsr encodings.
  function automatic logic f3_is_illegal(input logic [2:0] f3);
    return f3[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/csr_sequencer.sv
// Issues a committed Zicsr instruction to the CSR file as one or two
// single-beat requests and reports a writeback or an illegal-instruction trap.
module csr_sequencer
  import csr_seq_pkg::*;
#(
  parameter int unsigned ROB_ID_W = 6
) (
  input  logic                  cpu_clock_i,
  input  logic                  cpu_reset_i,
  input  logic                  csr_valid_i,
  output logic                  csr_ready_o,
  input  logic [2:0]            csr_funct3_i,
  input  logic [11:0]           csr_address_i,
  input  logic [4:0]            csr_rs1_i,
  input  logic [31:0]           csr_rs1_data_i,
  input  logic [4:0]            csr_rd_i,
  input  logic [ROB_ID_W-1:0]   csr_rob_id_i,
  input  logic [31:0]           csr_insn_i,
  input  logic                  flush_i,
  output logic                  tmu_valid_o,
  output logic [11:0]           tmu_address_o,
  output logic [1:0]            tmu_opcode_o,
  output logic                  tmu_wr_en_o,
  output logic [31:0]           tmu_data_o,
  input  logic                  tmu_done_i,
  input  logic                  tmu_excp_i,
  input  logic [31:0]           tmu_data_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [31:0]           wb_data_o,
  output logic [ROB_ID_W-1:0]   wb_rob_id_o,
  output logic                  flush_o,
  output logic                  excp_valid_o,
  output logic [3:0]            excp_cause_o,
  output logic [31:0]           excp_tval_o,
  output logic [ROB_ID_W-1:0]   excp_rob_id_o
);

  state_e                  state_q, state_d;
  logic [CSR_ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]              op_q, op_d;
  logic                    two_phase_q, two_phase_d;
  logic                    has_write_q, has_write_d;
  logic [XLEN-1:0]         wdata_q, wdata_d;
  logic [XLEN-1:0]         old_q, old_d;
  logic [REG_IDX_W-1:0]    rd_q, rd_d;
  logic [ROB_ID_W-1:0]     rob_q, rob_d;
  logic [XLEN-1:0]         insn_q, insn_d;
  logic                    drain_done_q, drain_done_d;

  logic                    accept_c;
  logic [XLEN-1:0]         operand_c;
  logic [XLEN-1:0]         merged_c;

  // State and instruction latch.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      op_q         <= '0;
      two_phase_q  <= 1'b0;
      has_write_q  <= 1'b0;
      wdata_q      <= '0;
      old_q        <= '0;
      rd_q         <= '0;
      rob_q        <= '0;
      insn_q       <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      two_phase_q  <= two_phase_d;
      has_write_q  <= has_write_d;
      wdata_q      <= wdata_d;
      old_q        <= old_d;
      rd_q         <= rd_d;
      rob_q        <= rob_d;
      insn_q       <= insn_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign accept_c  = (state_q == ST_IDLE) && csr_valid_i && !flush_i;
  assign operand_c = csr_funct3_i[2] ? XLEN'(csr_rs1_i) : csr_rs1_data_i;

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_c) state_d = f3_is_illegal(csr_funct3_i) ? ST_EXCP : ST_REQ1;
      ST_REQ1:  state_d = flush_i ? ST_IDLE : ST_WAIT1;
      ST_WAIT1: begin
        if (flush_i)         state_d = ST_DRAIN;
        else if (tmu_done_i) state_d = tmu_excp_i ? ST_EXCP : (two_phase_q ? ST_REQ2 : ST_DONE);
      end
      // The second strobe is already on the bus, so a kill must still drain it.
      ST_REQ2:  state_d = flush_i ? ST_DRAIN : ST_WAIT2;
      ST_WAIT2: begin
        if (flush_i)         state_d = ST_DRAIN;
        else if (tmu_done_i) state_d = tmu_excp_i ? ST_EXCP : ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_EXCP:  state_d = ST_IDLE;
      ST_DRAIN: if (drain_done_q || tmu_done_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read-modify-write merge of the old value with the latched operand.
  always_comb begin
    if (op_q == F3_RS[1:0])      merged_c = tmu_data_i | wdata_q;
    else if (op_q == F3_RC[1:0]) merged_c = tmu_data_i & ~wdata_q;
    else                         merged_c = wdata_q;
  end

  // Datapath latch updates.
  always_comb begin
    addr_d       = addr_q;
    op_d         = op_q;
    two_phase_d  = two_phase_q;
    has_write_d  = has_write_q;
    wdata_d      = wdata_q;
    old_d        = old_q;
    rd_d         = rd_q;
    rob_d        = rob_q;
    insn_d       = insn_q;
    drain_done_d = drain_done_q;

    if (accept_c) begin
      addr_d       = csr_address_i;
      op_d         = csr_funct3_i[1:0];
      has_write_d  = (csr_funct3_i[1:0] == F3_RW[1:0]) || (csr_rs1_i != '0);
      two_phase_d  = (csr_funct3_i[1:0] != F3_RW[1:0]) && (csr_rs1_i != '0);
      wdata_d      = operand_c;
      old_d        = '0;
      rd_d         = csr_rd_i;
      rob_d        = csr_rob_id_i;
      insn_d       = csr_insn_i;
      drain_done_d = 1'b0;
    end

    if ((state_q == ST_WAIT1) && tmu_done_i && !tmu_excp_i && !flush_i) begin
      old_d   = tmu_data_i;
      wdata_d = merged_c;
    end

    // A response arriving alongside the kill means DRAIN has nothing left to wait for.
    if ((state_q == ST_WAIT1) || (state_q == ST_WAIT2)) drain_done_d = flush_i && tmu_done_i;
    else if (state_q == ST_REQ2)                         drain_done_d = 1'b0;
  end

  // Outputs decoded from the state register and the latch.
  always_comb begin
    csr_ready_o   = (state_q == ST_IDLE);
    tmu_valid_o   = (state_q == ST_REQ1) || (state_q == ST_REQ2);
    tmu_opcode_o  = tmu_valid_o ? TMU_OP_WRITE : TMU_OP_NONE;
    tmu_wr_en_o   = (state_q == ST_REQ2) ||
                    ((state_q == ST_REQ1) && has_write_q && !two_phase_q);
    tmu_address_o = addr_q;
    tmu_data_o    = wdata_q;
    wb_valid_o    = (state_q == ST_DONE);
    wb_rd_o       = rd_q;
    wb_data_o     = old_q;
    wb_rob_id_o   = rob_q;
    flush_o       = (state_q == ST_DONE) && has_write_q;
    excp_valid_o  = (state_q == ST_EXCP);
    excp_cause_o  = excp_valid_o ? CAUSE_ILLEGAL_INSN : 4'd0;
    excp_tval_o   = insn_q;
    excp_rob_id_o = rob_q;
  end

endmodule

// File: tb/tb_csr_sequencer.sv
// Scoreboard bench for csr_sequencer with a one-cycle-latency CSR file model.
module tb_csr_sequencer;
  import csr_seq_pkg::*;

  localparam int unsigned ROB_ID_W = 6;

  logic                cpu_clock_i = 1'b0;
  logic                cpu_reset_i = 1'b1;
  logic                csr_valid_i = 1'b0;
  logic                csr_ready_o;
  logic [2:0]          csr_funct3_i = '0;
  logic [11:0]         csr_address_i = '0;
  logic [4:0]          csr_rs1_i = '0;
  logic [31:0]         csr_rs1_data_i = '0;
  logic [4:0]          csr_rd_i = '0;
  logic [ROB_ID_W-1:0] csr_rob_id_i = '0;
  logic [31:0]         csr_insn_i = '0;
  logic                flush_i = 1'b0;
  logic                tmu_valid_o;
  logic [11:0]         tmu_address_o;
  logic [1:0]          tmu_opcode_o;
  logic                tmu_wr_en_o;
  logic [31:0]         tmu_data_o;
  logic                tmu_done_i = 1'b0;
  logic                tmu_excp_i = 1'b0;
  logic [31:0]         tmu_data_i = '0;
  logic                wb_valid_o;
  logic [4:0]          wb_rd_o;
  logic [31:0]         wb_data_o;
  logic [ROB_ID_W-1:0] wb_rob_id_o;
  logic                flush_o;
  logic                excp_valid_o;
  logic [3:0]          excp_cause_o;
  logic [31:0]         excp_tval_o;
  logic [ROB_ID_W-1:0] excp_rob_id_o;

  csr_sequencer #(.ROB_ID_W(ROB_ID_W)) dut (
    .cpu_clock_i(cpu_clock_i), .cpu_reset_i(cpu_reset_i),
    .csr_valid_i(csr_valid_i), .csr_ready_o(csr_ready_o),
    .csr_funct3_i(csr_funct3_i), .csr_address_i(csr_address_i),
    .csr_rs1_i(csr_rs1_i), .csr_rs1_data_i(csr_rs1_data_i),
    .csr_rd_i(csr_rd_i), .csr_rob_id_i(csr_rob_id_i), .csr_insn_i(csr_insn_i),
    .flush_i(flush_i),
    .tmu_valid_o(tmu_valid_o), .tmu_address_o(tmu_address_o),
    .tmu_opcode_o(tmu_opcode_o), .tmu_wr_en_o(tmu_wr_en_o), .tmu_data_o(tmu_data_o),
    .tmu_done_i(tmu_done_i), .tmu_excp_i(tmu_excp_i), .tmu_data_i(tmu_data_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .wb_rob_id_o(wb_rob_id_o), .flush_o(flush_o),
    .excp_valid_o(excp_valid_o), .excp_cause_o(excp_cause_o),
    .excp_tval_o(excp_tval_o), .excp_rob_id_o(excp_rob_id_o)
  );

  always #5 cpu_clock_i = ~cpu_clock_i;

  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] data;
    int          cyc;
  } strobe_t;

  typedef struct {
    logic                is_excp;
    logic [4:0]          rd;
    logic [31:0]         data;
    logic                flush;
    logic [ROB_ID_W-1:0] rob;
    logic [31:0]         tval;
    int                  cyc;
  } result_t;

  strobe_t     exp_strobes[$];
  result_t     exp_results[$];
  logic [31:0] csr_file [logic [11:0]];
  logic [31:0] ref_csr  [logic [11:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic        prev_strobe = 1'b0;
  logic        rsp_pend    = 1'b0;
  logic [11:0] rsp_addr    = '0;
  logic        rsp_wr      = 1'b0;
  logic [31:0] rsp_data    = '0;
  logic        stray_req   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge cpu_clock_i);
    #1;
  endtask

  function automatic void set_csr(input logic [11:0] a, input logic [31:0] v);
    csr_file[a] = v;
    ref_csr[a]  = v;
  endfunction

  always @(posedge cpu_clock_i) cyc <= cyc + 1;

  // CSR file: answers every strobe exactly one cycle later; read-only space rejects writes.
  always @(posedge cpu_clock_i) begin
    #1;
    if (rsp_pend) begin
      tmu_done_i = 1'b1;
      tmu_excp_i = rsp_wr && (rsp_addr[11:10] == 2'b11);
      tmu_data_i = csr_file.exists(rsp_addr) ? csr_file[rsp_addr] : 32'h0;
      if (rsp_wr && !tmu_excp_i) csr_file[rsp_addr] = rsp_data;
      rsp_pend = 1'b0;
    end else begin
      tmu_done_i = stray_req;
      tmu_excp_i = 1'b0;
      tmu_data_i = stray_req ? 32'hA5A5_5A5A : 32'h0;
      stray_req  = 1'b0;
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT strobes or completes.
  always @(negedge cpu_clock_i) begin : monitor
    strobe_t s;
    result_t r;
    if (tmu_valid_o) begin
      check_eq("strobe_b2b", 64'(prev_strobe), 64'd0);
      check_eq("tmu_opcode", 64'(tmu_opcode_o), 64'(TMU_OP_WRITE));
      check_eq("strobe_expected", 64'(exp_strobes.size() != 0), 64'd1);
      if (exp_strobes.size() != 0) begin
        s = exp_strobes.pop_front();
        check_eq("strobe_cycle", 64'(cyc), 64'(s.cyc));
        check_eq("tmu_address", 64'(tmu_address_o), 64'(s.addr));
        check_eq("tmu_wr_en", 64'(tmu_wr_en_o), 64'(s.wr));
        if (s.wr) check_eq("tmu_data", 64'(tmu_data_o), 64'(s.data));
      end
      rsp_pend = 1'b1;
      rsp_addr = tmu_address_o;
      rsp_wr   = tmu_wr_en_o;
      rsp_data = tmu_data_o;
    end
    prev_strobe = tmu_valid_o;

    if (wb_valid_o || excp_valid_o) begin
      check_eq("wb_excp_exclusive", 64'(wb_valid_o && excp_valid_o), 64'd0);
      check_eq("result_expected", 64'(exp_results.size() != 0), 64'd1);
      if (exp_results.size() != 0) begin
        r = exp_results.pop_front();
        check_eq("result_cycle", 64'(cyc), 64'(r.cyc));
        check_eq("result_kind", 64'(excp_valid_o), 64'(r.is_excp));
        if (r.is_excp) begin
          check_eq("excp_cause", 64'(excp_cause_o), 64'(CAUSE_ILLEGAL_INSN));
          check_eq("excp_tval", 64'(excp_tval_o), 64'(r.tval));
          check_eq("excp_rob", 64'(excp_rob_id_o), 64'(r.rob));
          check_eq("flush_on_excp", 64'(flush_o), 64'd0);
        end else begin
          check_eq("wb_rd", 64'(wb_rd_o), 64'(r.rd));
          check_eq("wb_data", 64'(wb_data_o), 64'(r.data));
          check_eq("wb_rob", 64'(wb_rob_id_o), 64'(r.rob));
          check_eq("wb_flush", 64'(flush_o), 64'(r.flush));
        end
      end
    end else if (flush_o) begin
      check_eq("flush_without_wb", 64'(flush_o), 64'd0);
    end
  end

  // Drives one instruction for one cycle and pushes the reference outcome.
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                       input logic [31:0] rs1_data, input logic [4:0] rd,
                       input logic [ROB_ID_W-1:0] rob, input logic [31:0] insn,
                       input bit abort, output int t0, output int lat);
    strobe_t     s;
    result_t     r;
    logic [31:0] operand, old, nv;
    logic        two, hasw, ro, rej;
    t0       = cyc;
    operand  = f3[2] ? {27'd0, rs1} : rs1_data;
    old      = ref_csr.exists(addr) ? ref_csr[addr] : 32'h0;
    ro       = (addr[11:10] == 2'b11);
    hasw     = (f3[1:0] == 2'b01) || (rs1 != 5'd0);
    two      = (f3[1:0] != 2'b01) && (rs1 != 5'd0);
    r.rd     = rd;
    r.rob    = rob;
    r.tval   = insn;
    r.data   = old;
    r.flush  = 1'b0;
    r.is_excp = 1'b0;
    if (f3[1:0] == 2'b00) begin
      lat = 2;
      r.is_excp = 1'b1;
      r.cyc = t0 + 1;
    end else if (!two) begin
      lat = 4;
      rej = hasw && ro;
      s.addr = addr; s.wr = hasw; s.data = operand; s.cyc = t0 + 1;
      exp_strobes.push_back(s);
      if (hasw && !rej) ref_csr[addr] = operand;
      r.is_excp = rej;
      r.flush   = hasw;
      r.cyc     = t0 + 3;
    end else begin
      lat = 6;
      s.addr = addr; s.wr = 1'b0; s.data = 32'h0; s.cyc = t0 + 1;
      exp_strobes.push_back(s);
      nv = (f3[1:0] == 2'b10) ? (old | operand) : (old & ~operand);
      if (!abort) begin
        s.wr = 1'b1; s.data = nv; s.cyc = t0 + 3;
        exp_strobes.push_back(s);
        if (!ro) ref_csr[addr] = nv;
      end
      r.is_excp = ro;
      r.flush   = 1'b1;
      r.cyc     = t0 + 5;
    end
    if (!abort) exp_results.push_back(r);

    csr_valid_i    = 1'b1;
    csr_funct3_i   = f3;
    csr_address_i  = addr;
    csr_rs1_i      = rs1;
    csr_rs1_data_i = rs1_data;
    csr_rd_i       = rd;
    csr_rob_id_i   = rob;
    csr_insn_i     = insn;
    step();
    csr_valid_i    = 1'b0;
    csr_rs1_data_i = $urandom;
  endtask

  // Checks the exact cycle ready returns and that nothing is left outstanding.
  task automatic wait_ready(input int t0, input int lat, input string tag);
    while (cyc < t0 + lat - 1) step();
    @(negedge cpu_clock_i);
    check_eq({tag, "_busy"}, 64'(csr_ready_o), 64'd0);
    step();
    @(negedge cpu_clock_i);
    check_eq({tag, "_ready"}, 64'(csr_ready_o), 64'd1);
    check_eq({tag, "_results_left"}, 64'(exp_results.size()), 64'd0);
    check_eq({tag, "_strobes_left"}, 64'(exp_strobes.size()), 64'd0);
    step();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t0, lat;
    logic [11:0] addrs [6];
    addrs[0] = 12'h340; addrs[1] = 12'h341; addrs[2] = 12'h300;
    addrs[3] = 12'h305; addrs[4] = 12'hF14; addrs[5] = 12'hC00;
    set_csr(12'h340, 32'h0000_0000);
    set_csr(12'h341, 32'h0000_0000);
    set_csr(12'h300, 32'h0000_1888);
    set_csr(12'h305, 32'h0000_0100);
    set_csr(12'hF14, 32'h0000_0000);
    set_csr(12'hF11, 32'h0000_ABCD);
    set_csr(12'hC00, 32'h0000_0055);

    repeat (3) step();
    @(negedge cpu_clock_i);
    check_eq("rst_ready", 64'(csr_ready_o), 64'd1);
    check_eq("rst_tmu_valid", 64'(tmu_valid_o), 64'd0);
    check_eq("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check_eq("rst_flush", 64'(flush_o), 64'd0);
    check_eq("rst_excp_valid", 64'(excp_valid_o), 64'd0);
    check_eq("rst_wb_data", 64'(wb_data_o), 64'd0);
    check_eq("rst_excp_tval", 64'(excp_tval_o), 64'd0);
    check_eq("rst_tmu_data", 64'(tmu_data_o), 64'd0);
    check_eq("rst_tmu_address", 64'(tmu_address_o), 64'd0);
    step();
    cpu_reset_i = 1'b0;
    step();

    issue(F3_RW, 12'h340, 5'd5, 32'hDEAD_BEEF, 5'd10, 6'd1, 32'h3402_9573, 1'b0, t0, lat);
    wait_ready(t0, lat, "csrrw");
    issue(F3_RS, 12'hF14, 5'd0, 32'h1234_5678, 5'd11, 6'd2, 32'hF140_25F3, 1'b0, t0, lat);
    wait_ready(t0, lat, "csrrs_x0");
    issue(F3_RCI, 12'h300, 5'd8, 32'hFFFF_FFFF, 5'd12, 6'd3, 32'h3004_7673, 1'b0, t0, lat);
    wait_ready(t0, lat, "csrrci");
    issue(F3_RW, 12'hF11, 5'd5, 32'h1111_2222, 5'd13, 6'd4, 32'hF112_96F3, 1'b0, t0, lat);
    wait_ready(t0, lat, "csrrw_ro");
    issue(3'b100, 12'h340, 5'd1, 32'h0, 5'd14, 6'd5, 32'h3400_C773, 1'b0, t0, lat);
    wait_ready(t0, lat, "f3_100");
    issue(3'b000, 12'h340, 5'd1, 32'h0, 5'd15, 6'd6, 32'h3400_87F3, 1'b0, t0, lat);
    wait_ready(t0, lat, "f3_000");
    issue(F3_RS, 12'h305, 5'd7, 32'h0, 5'd0, 6'd7, 32'h3053_A073, 1'b0, t0, lat);
    wait_ready(t0, lat, "csrrs_zero_operand");
    issue(F3_RWI, 12'h341, 5'd19, 32'h0, 5'd1, 6'd8, 32'h3419_D0F3, 1'b0, t0, lat);
    wait_ready(t0, lat, "csrrwi");

    // Kill while waiting for the read half of a read-modify-write.
    issue(F3_RS, 12'h305, 5'd3, 32'h0000_00F0, 5'd9, 6'd9, 32'h3051_A4F3, 1'b1, t0, lat);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    @(negedge cpu_clock_i);
    check_eq("flush_drain_busy", 64'(csr_ready_o), 64'd0);
    step();
    @(negedge cpu_clock_i);
    check_eq("flush_ready_2_after_done", 64'(csr_ready_o), 64'd1);
    repeat (3) step();
    check_eq("flush_strobes_left", 64'(exp_strobes.size()), 64'd0);

    // A kill presented together with a new instruction wins.
    csr_valid_i = 1'b1; flush_i = 1'b1;
    csr_funct3_i = F3_RW; csr_address_i = 12'h340; csr_rs1_i = 5'd2;
    step();
    csr_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge cpu_clock_i);
    check_eq("idle_flush_no_accept", 64'(csr_ready_o), 64'd1);
    step();
    @(negedge cpu_clock_i);
    check_eq("idle_flush_no_strobe", 64'(tmu_valid_o), 64'd0);
    step();

    // Reset while waiting for the write response, then a stray done in IDLE.
    issue(F3_RW, 12'h341, 5'd6, 32'h1234_5678, 5'd3, 6'd10, 32'h3413_1173, 1'b1, t0, lat);
    step();
    cpu_reset_i = 1'b1;
    step();
    cpu_reset_i = 1'b0;
    @(negedge cpu_clock_i);
    check_eq("midrst_wb_valid", 64'(wb_valid_o), 64'd0);
    check_eq("midrst_excp_valid", 64'(excp_valid_o), 64'd0);
    check_eq("midrst_tmu_valid", 64'(tmu_valid_o), 64'd0);
    check_eq("midrst_flush", 64'(flush_o), 64'd0);
    check_eq("midrst_ready", 64'(csr_ready_o), 64'd1);
    stray_req = 1'b1;
    step();
    @(negedge cpu_clock_i);
    check_eq("stray_done_seen", 64'(tmu_done_i), 64'd1);
    check_eq("stray_ready", 64'(csr_ready_o), 64'd1);
    step();
    @(negedge cpu_clock_i);
    check_eq("stray_ignored", 64'(csr_ready_o), 64'd1);
    check_eq("stray_no_wb", 64'(wb_valid_o), 64'd0);
    step();
    issue(F3_RW, 12'h341, 5'd6, 32'hCAFE_F00D, 5'd4, 6'd11, 32'h3413_1273, 1'b0, t0, lat);
    wait_ready(t0, lat, "post_reset_csrrw");

    for (int i = 0; i < 12; i++) begin
      issue(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 5)],
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom, 5'($urandom), 6'($urandom), $urandom, 1'b0, t0, lat);
      wait_ready(t0, lat, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
